// File: rtl/barrett_parallel_reduce.sv
// Pipelined Barrett reduction: result_o = x_i mod m_i, one operand set per cycle,
// fixed three-cycle latency after capture, caller supplies mu = floor(2^(2k)/m) and k.
module barrett_parallel_reduce #(
  parameter int DATA_LENGTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [DATA_LENGTH-1:0] x_i,
  input  logic [DATA_LENGTH-1:0] m_i,
  input  logic [DATA_LENGTH-1:0] mu_i,
  input  logic [DATA_LENGTH-1:0] m_bl_i,
  output logic                   valid_o,
  output logic [DATA_LENGTH-1:0] result_o
);

  localparam int W  = DATA_LENGTH;
  localparam int DW = 2 * DATA_LENGTH;

  // Handshake: there is no ready. An operand set presented with valid_i high at a
  // rising edge is always accepted; its result appears three edges later with valid_o
  // high for exactly one cycle. Sets leave in the order they entered.

  // Capture stage: the wide multiply starts from flops rather than from the ports.
  logic          in_valid;
  logic [W-1:0]  in_x;
  logic [W-1:0]  in_m;
  logic [W-1:0]  in_mu;
  logic [W-1:0]  in_k;

  // S1: q2 = (x >> (k-1)) * mu, with x, m, k travelling alongside.
  logic          s1_valid;
  logic [DW-1:0] s1_q2;
  logic [W-1:0]  s1_x;
  logic [W-1:0]  s1_m;
  logic [W-1:0]  s1_k;

  // S2: r0 = x - (q2 >> (k+1)) * m, always below 3m when preconditions hold.
  logic          s2_valid;
  logic [DW-1:0] s2_r0;
  logic [W-1:0]  s2_m;

  logic [W-1:0]  q1;
  logic [DW-1:0] q2;
  logic [DW-1:0] q3;
  logic [DW-1:0] r0;
  logic [DW-1:0] r1;
  logic [DW-1:0] r2;

  always_comb begin
    q1 = in_x >> (in_k - W'(1));
    q2 = DW'(q1) * DW'(in_mu);
  end

  always_comb begin
    q3 = s1_q2 >> (s1_k + W'(1));
    r0 = DW'(s1_x) - q3 * DW'(s1_m);
  end

  // Two conditional subtractions cover the full Barrett error bound.
  always_comb begin
    r1 = (s2_r0 >= DW'(s2_m)) ? s2_r0 - DW'(s2_m) : s2_r0;
    r2 = (r1 >= DW'(s2_m)) ? r1 - DW'(s2_m) : r1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_valid <= 1'b0;
      in_x     <= '0;
      in_m     <= '0;
      in_mu    <= '0;
      in_k     <= '0;
    end else begin
      in_valid <= valid_i;
      in_x     <= x_i;
      in_m     <= m_i;
      in_mu    <= mu_i;
      in_k     <= m_bl_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_q2    <= '0;
      s1_x     <= '0;
      s1_m     <= '0;
      s1_k     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_q2    <= q2;
      s1_x     <= in_x;
      s1_m     <= in_m;
      s1_k     <= in_k;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid <= 1'b0;
      s2_r0    <= '0;
      s2_m     <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_r0    <= r0;
      s2_m     <= s1_m;
    end
  end

  // Output register holds its value across cycles without a valid result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= s2_valid;
      if (s2_valid) begin
        result_o <= r2[W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_barrett_parallel_reduce.sv
// Directed bench for barrett_parallel_reduce: Dilithium and Kyber moduli, boundary
// values, a random back-to-back stream, mid-stream reset and gapped valid_i.
module tb_barrett_parallel_reduce;

  localparam int W = 64;
  localparam logic [W-1:0] QD    = 64'h7FE001;
  localparam logic [W-1:0] MUD   = 64'h802007;
  localparam logic [W-1:0] KD    = 64'd23;
  localparam logic [W-1:0] QK    = 64'hD01;
  localparam logic [W-1:0] MUK   = 64'h13AF;
  localparam logic [W-1:0] KK    = 64'd12;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic [W-1:0] x_i = '0;
  logic [W-1:0] m_i = '0;
  logic [W-1:0] mu_i = '0;
  logic [W-1:0] m_bl_i = '0;
  logic         valid_o;
  logic [W-1:0] result_o;

  int n_assert = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   vpipe = 4'b0;
  logic [W-1:0] held = '0;
  logic         pend_rst = 1'b1;
  logic         pend_valid = 1'b0;

  barrett_parallel_reduce #(.DATA_LENGTH(W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .x_i      (x_i),
    .m_i      (m_i),
    .mu_i     (mu_i),
    .m_bl_i   (m_bl_i),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: inputs seen at negedge are those the next posedge samples.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (pend_rst) begin
      vpipe = 4'b0;
      held  = '0;
      exp_q.delete();
    end else begin
      vpipe = {vpipe[2:0], pend_valid};
    end
    check("valid_o", W'(valid_o), W'(vpipe[3]));
    if (vpipe[3]) begin
      n_assert++;
      assert (exp_q.size() > 0) else begin
        n_fail++;
        $error("FAIL result_order: observed result %h with no expected entry, expected none", result_o);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", result_o, e);
        held = e;
      end
    end else begin
      check("result_hold", result_o, held);
    end
    pend_rst   = rst_i;
    pend_valid = valid_i;
  end

  // Driver tasks
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] m,
                          input logic [W-1:0] mu, input logic [W-1:0] k,
                          input logic [W-1:0] e);
    @(posedge clk);
    #1;
    rst_i   = 1'b0;
    valid_i = 1'b1;
    x_i     = x;
    m_i     = m;
    mu_i    = mu;
    m_bl_i  = k;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      x_i     = {$urandom(), $urandom()};
      m_i     = {$urandom(), $urandom()};
      mu_i    = {$urandom(), $urandom()};
      m_bl_i  = {$urandom(), $urandom()};
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    rst_i   = 1'b1;
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    logic [W-1:0] rx;

    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    idle(2);

    // Zero, m-1 and m, each as an isolated pulse
    drive_op(64'h0,      QD, MUD, KD, 64'h0);
    idle(1);
    drive_op(64'h7FE000, QD, MUD, KD, 64'h7FE000);
    idle(1);
    drive_op(64'h7FE001, QD, MUD, KD, 64'h0);
    idle(5);

    // Largest product of residues and a 32-bit all-ones value
    drive_op(64'h3FE004000000, QD, MUD, KD, 64'h1);
    drive_op(64'hFFFFFFFF,     QD, MUD, KD, 64'h3FFDFF);
    idle(5);

    // Back-to-back random stream below 2^46
    for (int i = 0; i < 1000; i++) begin
      rx = {18'b0, 14'($urandom_range(0, 16383)), 32'($urandom())};
      drive_op(rx, QD, MUD, KD, rx % QD);
    end
    idle(5);

    // Modulus switching every cycle
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) drive_op(64'h123456, QD, MUD, KD, 64'h123456);
      else            drive_op(64'h123456, QK, MUK, KK, 64'h4F0);
    end
    idle(5);

    // Reset with two operations in flight, then one fresh operation
    drive_op(64'h3FE004000000, QD, MUD, KD, 64'h1);
    drive_op(64'h7FE000,       QD, MUD, KD, 64'h7FE000);
    do_reset(1);
    idle(2);
    drive_op(64'hFFFFFFFF, QD, MUD, KD, 64'h3FFDFF);
    idle(5);

    // Gapped valid pattern 1,0,0,1
    drive_op(64'h3FFF, QK, MUK, KK, 64'h3FFF % 64'hD01);
    idle(2);
    drive_op(64'hD02, QK, MUK, KK, 64'h1);
    idle(6);

    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain: observed %0d results outstanding, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
